// File: rtl/cpu_core_gen_if.sv
// Bus bundle between the LED-matrix CPU core and its host: run/step control,
// program ROM port, buttons and the LED / matrix display outputs.
interface cpu_core_gen_if #(
  parameter int PC_W = 11
);
  logic            run;
  logic            step;
  logic [7:0]      btn;
  logic [7:0]      rom_data;
  logic [2:0]      scan_sel;
  logic [PC_W-1:0] rom_addr;
  logic [3:0]      led;
  logic [7:0]      row;
  logic [7:0]      col;
  logic [PC_W-1:0] pc_out;
  logic            halted;
  logic            retire;

  modport master (
    output run, step, btn, rom_data, scan_sel,
    input  rom_addr, led, row, col, pc_out, halted, retire
  );

  modport slave (
    input  run, step, btn, rom_data, scan_sel,
    output rom_addr, led, row, col, pc_out, halted, retire
  );
endinterface

// File: rtl/cpu_core_gen.sv
// Parametrised 8-register CPU core: r5 = buttons, r6 = LEDs, r7 = PC.
// Fetch/execute FSM with ROM_LAT-cycle fetch, run/single-step control and a retire strobe.
module cpu_core_gen #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 11,
  parameter int ROM_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  cpu_core_gen_if.slave bus
);
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait;
  logic [DATA_W-1:0] r_regs [8];
  logic              r_c;
  logic              r_z;
  logic              r_step_d;
  logic [PC_W-1:0]   r_pc_out;
  logic              r_retire;
  logic              r_halted;

  logic [4:0]        w_op;
  logic [2:0]        w_sss;
  logic [DATA_W-1:0] w_rs;
  logic [DATA_W-1:0] w_r0;
  logic [DATA_W:0]   w_sum;
  logic [PC_W-1:0]   w_pc;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_tgt;
  logic              w_wr_en;
  logic [2:0]        w_wr_idx;
  logic [DATA_W-1:0] w_wr_val;
  logic              w_upd_z;
  logic              w_c_next;
  logic              w_z_next;
  logic [PC_W-1:0]   w_pc_next;
  logic              w_halt;
  logic [7:0]        w_scan_byte;
  logic [7:0]        w_row;

  assign w_op     = bus.rom_data[7:3];
  assign w_sss    = bus.rom_data[2:0];
  assign w_rs     = r_regs[w_sss];
  assign w_r0     = r_regs[0];
  assign w_pc     = PC_W'(r_regs[7]);
  assign w_pc_inc = w_pc + PC_W'(1);
  assign w_tgt    = PC_W'(bus.rom_data[3:0]);

  // Decode/execute of the byte on rom_data; only committed in EXEC.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = 3'd0;
    w_wr_val  = w_rs;
    w_upd_z   = 1'b0;
    w_sum     = '0;
    w_c_next  = r_c;
    w_z_next  = r_z;
    w_pc_next = w_pc_inc;
    w_halt    = 1'b0;
    casez (w_op)
      5'b00???: begin w_wr_en = 1'b1; w_wr_idx = w_op[2:0]; w_wr_val = w_rs; end
      5'b01000: begin
        w_sum = {1'b0, w_r0} + {1'b0, w_rs};
        w_wr_en = 1'b1; w_wr_val = w_sum[DATA_W-1:0]; w_c_next = w_sum[DATA_W]; w_upd_z = 1'b1;
      end
      5'b01001: begin w_wr_en = 1'b1; w_wr_val = w_r0 | w_rs; w_upd_z = 1'b1; end
      5'b01010: begin w_wr_en = 1'b1; w_wr_val = w_r0 & w_rs; w_upd_z = 1'b1; end
      5'b01011: begin w_wr_en = 1'b1; w_wr_val = w_r0 ^ w_rs; w_upd_z = 1'b1; end
      5'b01100: begin
        w_sum = {1'b0, w_rs} + (DATA_W+1)'(1);
        w_wr_en = 1'b1; w_wr_idx = w_sss; w_wr_val = w_sum[DATA_W-1:0];
        w_c_next = w_sum[DATA_W]; w_upd_z = 1'b1;
      end
      5'b01101: begin w_wr_en = 1'b1; w_wr_idx = w_sss; w_wr_val = ~w_rs; w_upd_z = 1'b1; end
      5'b01110: begin w_wr_en = 1'b1; w_wr_idx = w_sss; w_wr_val = {w_rs[0], w_rs[DATA_W-1:1]}; end
      5'b01111: begin w_wr_en = 1'b1; w_wr_idx = w_sss; w_wr_val = {w_rs[DATA_W-2:0], w_rs[DATA_W-1]}; end
      5'b1000?: begin w_pc_next = r_c ? w_pc_inc : w_tgt; w_c_next = 1'b0; end
      5'b1001?: w_pc_next = w_tgt;
      5'b1010?: begin w_wr_en = 1'b1; w_wr_val = DATA_W'(bus.rom_data[3:0]); end
      5'b1011?: begin w_pc_next = r_z ? w_tgt : w_pc_inc; w_z_next = 1'b0; end
      5'b11000: begin
        w_sum = {1'b0, w_r0} - {1'b0, w_rs};
        w_wr_en = 1'b1; w_wr_val = w_sum[DATA_W-1:0]; w_c_next = w_sum[DATA_W]; w_upd_z = 1'b1;
      end
      5'b11111: begin w_pc_next = w_pc; w_halt = 1'b1; end
      default: ;
    endcase
    if (w_upd_z) w_z_next = (w_wr_val == '0);
    // Any write landing in r7 becomes the new PC, with no increment.
    if (w_wr_en && (w_wr_idx == 3'd7)) w_pc_next = PC_W'(w_wr_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_step_d <= 1'b0;
      r_pc_out <= '0;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_step_d <= bus.step;
      r_retire <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.run || (bus.step && !r_step_d)) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
          end
        end
        S_FETCH: begin
          if (r_wait == CNT_W'(ROM_LAT - 1)) begin
            r_state  <= S_EXEC;
            r_retire <= 1'b1;
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (w_wr_en) r_regs[w_wr_idx] <= w_wr_val;
          r_regs[7] <= DATA_W'(w_pc_next);
          r_c       <= w_c_next;
          r_z       <= w_z_next;
          r_pc_out  <= w_pc;
          if (w_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (bus.run) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: ;
      endcase
      // Button sampling overrides any instruction write to r5.
      r_regs[5] <= DATA_W'(bus.btn);
    end
  end

  assign w_scan_byte = r_regs[bus.scan_sel][7:0];

  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    assign w_row[gi] = w_scan_byte[7-gi];
  end

  assign bus.row      = w_row;
  assign bus.col      = ~(8'd1 << bus.scan_sel);
  assign bus.rom_addr = w_pc;
  assign bus.led      = r_regs[6][3:0];
  assign bus.pc_out   = r_pc_out;
  assign bus.halted   = r_halted;
  assign bus.retire   = r_retire;
endmodule
